// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register of the LEGv8 CPU.
//   Holds the PC and drives it straight out as the instruction-memory address.
//   Selects the next PC: a taken branch first, then a stall hold, then sequential +4.
//   Registers the fetched word into IF/ID and presents instr[31:21] as the opcode.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall             hold PC and IF/ID
//   flush             squash IF/ID on the next edge
//   br_taken          redirect PC to br_target on the next edge
//   br_target         redirect address; bits [1:0] are ignored
//   imem_addr         instruction-memory address (= pc)
//   imem_rdata        instruction at imem_addr, valid in the same cycle
//   pc                current PC register
//   if_id_valid       IF/ID holds a live instruction
//   if_id_instr       registered instruction (0 for a bubble)
//   if_id_pc          PC of if_id_instr
//   if_id_pc4         if_id_pc + 4, the BL link value
//   opcode            if_id_instr[31:21], 0 for a bubble
//   fetch_count       saturating count of instructions loaded into IF/ID
module fetch_stage #(
  parameter int unsigned             ADDR_W   = 64,
  parameter int unsigned             INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0,
  parameter int unsigned             CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc4,
  output logic [10:0]        opcode,
  output logic [CNT_W-1:0]   fetch_count
);

  // What IF/ID does on the coming edge.
  typedef enum logic [1:0] {
    IFID_LOAD   = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_SQUASH = 2'd2
  } ifid_act_e;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  br_aligned;

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic [ADDR_W-1:0]  ipc4_q, ipc4_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  ifid_act_e          ifid_act;

  assign pc_plus4   = pc_q + ADDR_W'(4);
  // Masking rather than concatenating keeps every br_target bit referenced.
  assign br_aligned = br_target & ~ADDR_W'(3);

  // Next PC: branch redirect overrides stall.
  always_comb begin
    pc_d = pc_plus4;
    if (br_taken) begin
      pc_d = br_aligned;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // A taken branch squashes the sequential fetch sitting behind it, and a
  // flush beats a stall so the bubble goes in even while the PC is frozen.
  always_comb begin
    ifid_act = IFID_LOAD;
    if (flush || br_taken) begin
      ifid_act = IFID_SQUASH;
    end else if (stall) begin
      ifid_act = IFID_HOLD;
    end
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    cnt_d   = cnt_q;
    unique case (ifid_act)
      IFID_SQUASH: begin
        valid_d = 1'b0;
        instr_d = '0;
        ipc_d   = '0;
        ipc4_d  = '0;
      end
      IFID_HOLD: begin
      end
      IFID_LOAD: begin
        valid_d = 1'b1;
        instr_d = imem_rdata;
        ipc_d   = pc_q;
        ipc4_d  = pc_plus4;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign if_id_pc4   = ipc4_q;
  assign opcode      = valid_q ? instr_q[31:21] : 11'b0;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [63:0] ipc;
    logic [63:0] ipc4;
    logic [63:0] pc;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT
  logic        reset = 1'b1, stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
  logic [63:0] br_target = '0;
  logic [63:0] imem_addr, pc, if_id_pc, if_id_pc4;
  logic [31:0] imem_rdata, if_id_instr, fetch_count;
  logic        if_id_valid;
  logic [10:0] opcode;

  // wrap / saturation DUT
  logic        reset1 = 1'b1;
  logic        zero1 = 1'b0;
  logic [63:0] zero64 = '0;
  logic [63:0] imem_addr1, pc1, if_id_pc1, if_id_pc41;
  logic [31:0] imem_rdata1, if_id_instr1;
  logic        if_id_valid1;
  logic [10:0] opcode1;
  logic [3:0]  fetch_count1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  exp_t q[$];
  exp_t m;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return a[31:0] ^ 32'h9100_0421;
  endfunction

  assign imem_rdata  = mem(imem_addr);
  assign imem_rdata1 = mem(imem_addr1);

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .br_taken(br_taken), .br_target(br_target), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .pc(pc), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .opcode(opcode), .fetch_count(fetch_count)
  );

  fetch_stage #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(WRAP_PC), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset1), .stall(zero1), .flush(zero1),
    .br_taken(zero1), .br_target(zero64), .imem_addr(imem_addr1),
    .imem_rdata(imem_rdata1), .pc(pc1), .if_id_valid(if_id_valid1),
    .if_id_instr(if_id_instr1), .if_id_pc(if_id_pc1), .if_id_pc4(if_id_pc41),
    .opcode(opcode1), .fetch_count(fetch_count1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the reference model, queue the
  // expected post-edge state, then compare after the edge.
  task automatic step(input logic rst, input logic st, input logic fl,
                      input logic br, input logic [63:0] tgt);
    exp_t e;
    reset = rst; stall = st; flush = fl; br_taken = br; br_target = tgt;
    #1;
    if (!rst) chk("imem_addr", imem_addr, m.pc);
    e = m;
    if (rst) begin
      e.pc = '0; e.v = 1'b0; e.instr = '0; e.ipc = '0; e.ipc4 = '0; e.cnt = '0;
    end else begin
      if (fl || br) begin
        e.v = 1'b0; e.instr = '0; e.ipc = '0; e.ipc4 = '0;
      end else if (!st) begin
        e.v = 1'b1; e.instr = mem(m.pc); e.ipc = m.pc; e.ipc4 = m.pc + 64'd4;
        if (m.cnt != 32'hFFFF_FFFF) e.cnt = m.cnt + 32'd1;
      end
      if (br)       e.pc = {tgt[63:2], 2'b00};
      else if (!st) e.pc = m.pc + 64'd4;
    end
    q.push_back(e);
    @(posedge clk); #1;
    m = q.pop_front();
    chk("pc",          pc,                     m.pc);
    chk("if_id_valid", 64'(if_id_valid),       64'(m.v));
    chk("if_id_instr", 64'(if_id_instr),       64'(m.instr));
    chk("if_id_pc",    if_id_pc,               m.ipc);
    chk("if_id_pc4",   if_id_pc4,              m.ipc4);
    chk("opcode",      64'(opcode),            m.v ? 64'(m.instr[31:21]) : 64'd0);
    chk("fetch_count", 64'(fetch_count),       64'(m.cnt));
  endtask

  initial begin : main
    m = '{v: 1'b0, instr: '0, ipc: '0, ipc4: '0, pc: '0, cnt: '0};
    @(posedge clk); #1;

    // reset two cycles
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_opcode", 64'(opcode), 64'd0);

    // first fetch
    step(0, 0, 0, 0, '0);
    chk("t1_instr",  64'(if_id_instr), 64'h9100_0421);
    chk("t1_opcode", 64'(opcode),      64'h488);
    chk("t1_pc4",    if_id_pc4,        64'd4);
    chk("t1_pc",     pc,               64'd4);
    step(0, 0, 0, 0, '0);
    chk("t1_pc8", pc, 64'd8);

    // stall 3 cycles at pc=8
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0);
    chk("t2_pc",  pc,                64'd8);
    chk("t2_cnt", 64'(fetch_count),  64'd2);

    // run to 0x10, then branch to 0x103 -> 0x100
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("t3_pre_pc", pc, 64'h10);
    step(0, 0, 0, 1, 64'h103);
    chk("t3_pc",     pc,              64'h100);
    chk("t3_valid",  64'(if_id_valid), 64'd0);
    chk("t3_opcode", 64'(opcode),      64'd0);
    step(0, 0, 0, 0, '0);
    chk("t3_ifpc",   if_id_pc,        64'h100);

    // flush+stall, then branch+stall
    step(0, 0, 0, 0, '0);
    step(0, 1, 1, 0, '0);
    chk("t4_pc",    pc,               64'h108);
    chk("t4_valid", 64'(if_id_valid), 64'd0);
    step(0, 1, 0, 1, 64'h20B);
    chk("t4_br_pc", pc,               64'h208);

    // random mix
    for (int i = 0; i < 40; i++) begin
      step(0, ($urandom_range(3) == 0), ($urandom_range(5) == 0),
           ($urandom_range(5) == 0), {32'h0, $urandom});
    end

    // reset mid-stream with a branch pending
    step(0, 0, 0, 0, '0);
    step(1, 0, 0, 1, 64'h400);
    chk("t6_pc",  pc,               64'd0);
    chk("t6_cnt", 64'(fetch_count), 64'd0);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);

    // wrap and saturation on the second instance
    reset1 = 1'b1;
    @(posedge clk); #1;
    chk("w_rst_pc",  pc1,                WRAP_PC);
    chk("w_rst_cnt", 64'(fetch_count1),  64'd0);
    reset1 = 1'b0;
    @(posedge clk); #1;
    chk("w_pc_fc",   pc1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_pc4_fc",  if_id_pc41, 64'hFFFF_FFFF_FFFF_FFFC);
    @(posedge clk); #1;
    chk("w_pc_0",    pc1, 64'd0);
    chk("w_pc4_0",   if_id_pc41, 64'd0);
    @(posedge clk); #1;
    chk("w_cnt3",    64'(fetch_count1), 64'd3);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
    end
    chk("w_cnt_sat", 64'(fetch_count1), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
